sio_uart_rx: RTL and testbench

//  Asynchronous serial receiver (8N1, LSB first) for the Z80 mini computer SIO path.

---
 rtl/sio_uart_rx.sv | 96 +++++++++
 tb/tb_sio_uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sio_uart_rx.sv
// sio_uart_rx: 8N1 LSB-first serial receiver with one-byte holding register,
// sticky framing/overrun flags and a CPU read strobe.
module sio_uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic        rxd_m_q, rxd_s_q, armed_q;
    logic [15:0] bit_cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shreg_q, rx_data_q;
    logic        rx_full_q, frame_err_q, overrun_q;
    logic        bit_end, deliver;

    assign bit_end   = bit_cnt_q == FULL;
    assign deliver   = state_q == STOP && bit_end;
    assign rx_data   = rx_data_q;
    assign rx_full   = rx_full_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 16'd0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_full_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_m_q   <= rxd;
            rxd_s_q   <= rxd_m_q;
            bit_cnt_q <= bit_cnt_q + 16'd1;
            case (state_q)
                // a new start edge is only accepted after the line has been seen high
                IDLE: begin
                    if (rxd_s_q) armed_q <= 1'b1;
                    else if (armed_q) begin
                        state_q   <= START;
                        bit_cnt_q <= 16'd0;
                    end
                end
                START: if (bit_cnt_q == HALF) begin
                    state_q   <= rxd_s_q ? IDLE : DATA;
                    bit_cnt_q <= 16'd0;
                    idx_q     <= 3'd0;
                end
                DATA: if (bit_end) begin
                    shreg_q   <= {rxd_s_q, shreg_q[7:1]};
                    idx_q     <= idx_q + 3'd1;
                    bit_cnt_q <= 16'd0;
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (bit_end) begin
                    state_q   <= IDLE;
                    bit_cnt_q <= 16'd0;
                    armed_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (rd) begin
                rx_full_q   <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            // a read on the delivery clock frees the register for the new byte
            if (deliver) begin
                if (!rx_full_q || rd) begin
                    rx_data_q <= shreg_q;
                    rx_full_q <= 1'b1;
                end else overrun_q <= 1'b1;
                if (!rxd_s_q) frame_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sio_uart_rx.sv
// tb_sio_uart_rx: random and directed frames against a holding-register model;
// a monitor checks the expected register state at every end of receiver activity.
module tb_sio_uart_rx;
    localparam int C = 16;
    localparam int STOP_N = 9 * C + C / 2 + 2;

    typedef struct {
        logic [7:0] d;
        logic       full, fe, ov;
    } exp_t;

    logic       clk, rst, rxd, rd;
    logic [7:0] rx_data;
    logic       rx_full, frame_err, overrun, busy;
    logic       busy_prev;
    int         errors, checks;
    exp_t       exp_q[$];
    logic [7:0] m_data;
    logic       m_full, m_fe, m_ov;

    sio_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rd(rd), .rx_data(rx_data),
        .rx_full(rx_full), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.d = m_data; e.full = m_full; e.fe = m_fe; e.ov = m_ov;
        return e;
    endfunction

    // every drop of busy outside reset is one finished frame or rejected glitch
    initial busy_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && busy_prev === 1'b1 && busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_end", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.full) check("mon_rx_data", rx_data, e.d);
                check("mon_rx_full", rx_full, e.full);
                check("mon_frame_err", frame_err, e.fe);
                check("mon_overrun", overrun, e.ov);
            end
        end
        busy_prev = busy;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxd = 1'b1;
            rd = 1'b0;
        end
    endtask

    task automatic do_rd();
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        m_full = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        check("rd_rx_full", rx_full, 0);
        check("rd_frame_err", frame_err, 0);
        check("rd_overrun", overrun, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_sim);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (rd_sim) begin m_full = 1'b0; m_fe = 1'b0; m_ov = 1'b0; end
        if (!m_full) begin m_data = d; m_full = 1'b1; end else m_ov = 1'b1;
        if (!stop) m_fe = 1'b1;
        exp_q.push_back(snap());
        for (int n = 0; n < 10 * C; n++) begin
            @(negedge clk);
            rxd = bits[n / C];
            rd = rd_sim && n == STOP_N;
        end
    endtask

    task automatic glitch();
        exp_q.push_back(snap());
        repeat (5) begin @(negedge clk); rxd = 1'b0; end
        idle(2 * C);
    endtask

    initial begin
        errors = 0; checks = 0;
        m_data = 8'h00; m_full = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        rst = 1'b1; rxd = 1'b1; rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_full", rx_full, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        idle(4);
        // single byte
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        do_rd();
        // glitch shorter than half a bit
        glitch();
        check("glitch_busy", busy, 0);
        check("glitch_rx_full", rx_full, 0);
        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(0);
        repeat (3 * C) begin @(negedge clk); rxd = 1'b0; end
        check("break_busy", busy, 0);
        check("break_rx_data", rx_data, 8'h3C);
        check("break_frame_err", frame_err, 1);
        check("break_no_extra", exp_q.size(), 0);
        idle(2 * C);
        do_rd();
        // overrun
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        check("ovr_rx_data", rx_data, 8'h11);
        check("ovr_overrun", overrun, 1);
        do_rd();
        send_frame(8'h33, 1'b1, 1'b0);
        idle(4);
        do_rd();
        // read on the same clock as delivery
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1);
        idle(4);
        check("simul_rx_data", rx_data, 8'h44);
        check("simul_overrun", overrun, 0);
        do_rd();
        // reset while receiving data bit 4
        for (int n = 0; n < 5 * C + 2; n++) begin
            logic [9:0] bits;
            bits = {1'b1, 8'h5A, 1'b0};
            @(negedge clk);
            rxd = bits[n / C];
        end
        rst = 1'b1; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_data = 8'h00; m_full = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_rx_full", rx_full, 0);
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        check("post_rst_rx_data", rx_data, 8'h5A);
        do_rd();
        // random traffic
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop, rsim;
            d = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            rsim = $urandom_range(0, 2) == 0;
            send_frame(d, stop, rsim);
            idle(stop ? $urandom_range(0, 20) : C + $urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) do_rd();
        end
        idle(2 * C);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
